issue_sched: RTL and testbench
==============================

# issue_sched

Oldest-first issue scheduler for the out-of-order core's scheduling stage. Consumes renamed instructions leaving the decode/rename→schedule pipeline register, holds them in an age-ordered window, wakes source operands on writeback tag broadcast, and issues one ready instruction per cycle to execute. Raises backpressure to hazard control when full.

## Interface
- DEPTH, 8: window entries, ≥2.
- PREG_W, 6: physical register tag width.
- PAYLOAD_W, 128: opaque instruction bundle (decoded fields + ALU pass-through), carried unmodified.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  enqueue request.
- in_ready  out  1  window not full (count < DEPTH).
- in_src1_tag, in_src2_tag  in  PREG_W  source physical tags.
- in_src1_rdy, in_src2_rdy  in  1  source already available (also 1 for unused sources).
- in_payload  in  PAYLOAD_W  bundle.
- wb_valid  in  1  writeback broadcast valid.
- wb_tag  in  PREG_W  produced physical tag.
- flush  in  1  discard all entries.
- issue_valid  out  1  a ready entry is offered.
- issue_ready  in  1  execute accepts this cycle.
- issue_payload  out  PAYLOAD_W  bundle of offered entry.
- stall_req  out  1  to hazard control; equals !in_ready.
- count  out  $clog2(DEPTH+1)  occupied entries.

## Operation
- Storage: compacting queue, slot 0 oldest; slots [0, count) valid. Entry = {src1_tag, src1_rdy, src2_tag, src2_rdy, payload}.
- Entry ready = src1_rdy & src2_rdy.
- Select: lowest-index ready slot; issue_valid = any ready & !flush; issue_payload = that slot's payload (don't-care, held 0 when no ready slot).
- Issue: issue_valid & issue_ready removes the selected slot at the edge; all higher slots shift down one.
- Enqueue: in_valid & in_ready writes at slot count, or count−1 if an issue occurs the same cycle. Enqueue and issue in one cycle leave count unchanged.
- Wakeup: wb_valid sets srcN_rdy on every valid slot whose srcN_tag == wb_tag (both sources independently). Same-cycle bypass: incoming entry with in_srcN_tag == wb_tag is written with srcN_rdy = 1.
- in_ready depends only on registered count (no combinational path from issue_ready); a full window does not accept even while issuing.
- Flush: highest priority; at the edge count → 0, all rdy bits cleared; enqueue, wakeup and issue that cycle are discarded; issue_valid forced 0 during flush.
- count arithmetic: count + enq − iss, never exceeds DEPTH or underflows.

## Timing
- Reset (async): count = 0, all slots invalid, rdy bits 0; outputs in_ready = 1, stall_req = 0, issue_valid = 0, issue_payload = 0.
- Enqueue-to-issue latency: an entry enqueued with both sources ready is offered the next cycle.
- Wakeup-to-issue: readiness is registered; an entry woken at edge N is offered in cycle N+1, not in cycle N.
- issue_valid/issue_payload are combinational from registered state only (plus flush).
- Offered entry may change between cycles if issue_ready = 0 and an older entry becomes ready; execute must not assume stability.
- stall_req tracks count == DEPTH in the same cycle.

## Structure
- Package sched_pkg: preg_t (logic [PREG_W-1:0]), sched_entry_t struct, default DEPTH/PREG_W constants.
- Sub-module sched_pick: DEPTH-wide find-first-set (lowest index) producing one-hot grant and index plus any-valid flag; used for selection.

## Test plan
- Reset mid-operation: fill 5 entries, pulse rst_n low → count = 0, issue_valid = 0, in_ready = 1 immediately.
- Age order: enqueue A, B, C all ready, issue_ready = 1 → issued A, B, C in consecutive cycles, count 3→0.
- Wakeup: enqueue A (src1 tag 12 not ready), then B ready → B issues first; wb_tag = 12 at cycle N → A offered cycle N+1.
- Bypass: enqueue with src2 tag 7 not ready while wb_tag = 7 → entry issues the following cycle.
- Full: DEPTH = 8, issue_ready = 0, 8 enqueues → in_ready = 0, stall_req = 1; 9th in_valid ignored; one issue → in_ready = 1 next cycle.
- Flush with simultaneous enqueue, wakeup and issue_ready = 1 → nothing issued, count = 0 next cycle, enqueued entry absent.

Source files
------------

// File: rtl/sched_pkg.sv
// sched_pkg: shared types and default sizes for the oldest-first issue scheduler.
//   SCHED_DEPTH / SCHED_PREG_W / SCHED_PAYLOAD_W : default window depth, tag and bundle widths
//   preg_t        : physical register tag
//   sched_entry_t : one window entry {src1_tag, src1_rdy, src2_tag, src2_rdy, payload}
package sched_pkg;
    localparam int SCHED_DEPTH     = 8;
    localparam int SCHED_PREG_W    = 6;
    localparam int SCHED_PAYLOAD_W = 128;

    typedef logic [SCHED_PREG_W-1:0] preg_t;

    typedef struct packed {
        preg_t                      src1_tag;
        logic                       src1_rdy;
        preg_t                      src2_tag;
        logic                       src2_rdy;
        logic [SCHED_PAYLOAD_W-1:0] payload;
    } sched_entry_t;
endpackage

// File: rtl/sched_pick.sv
// sched_pick: find-first-set (lowest index wins) over an N-bit request vector.
//   req   in  N          request bits
//   grant out N          one-hot grant of the lowest set request (0 when none)
//   idx   out clog2(N)   index of the granted request (0 when none)
//   any   out 1          at least one request set
module sched_pick #(
    parameter int N = 8
) (
    input  logic [N-1:0]         req,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);
    localparam int IW = $clog2(N);

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req[i] && !any) begin
                grant[i] = 1'b1;
                idx      = IW'(i);
                any      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/issue_sched.sv
// issue_sched: oldest-first issue window with tag wakeup, one issue per cycle.
//   clk, rst_n (async, active-low)
//   in_valid/in_ready, in_src{1,2}_tag, in_src{1,2}_rdy, in_payload : enqueue side
//   wb_valid, wb_tag                                              : writeback wakeup broadcast
//   flush                                                         : discard all entries
//   issue_valid/issue_ready, issue_payload                        : issue side
//   stall_req (= !in_ready), count                                : occupancy status
module issue_sched
    import sched_pkg::*;
#(
    parameter int DEPTH     = SCHED_DEPTH,
    parameter int PREG_W    = SCHED_PREG_W,
    parameter int PAYLOAD_W = SCHED_PAYLOAD_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [PREG_W-1:0]            in_src1_tag,
    input  logic [PREG_W-1:0]            in_src2_tag,
    input  logic                         in_src1_rdy,
    input  logic                         in_src2_rdy,
    input  logic [PAYLOAD_W-1:0]         in_payload,
    input  logic                         wb_valid,
    input  logic [PREG_W-1:0]            wb_tag,
    input  logic                         flush,
    output logic                         issue_valid,
    input  logic                         issue_ready,
    output logic [PAYLOAD_W-1:0]         issue_payload,
    output logic                         stall_req,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int IW = $clog2(DEPTH);

    typedef struct packed {
        logic [PREG_W-1:0]    src1_tag;
        logic                 src1_rdy;
        logic [PREG_W-1:0]    src2_tag;
        logic                 src2_rdy;
        logic [PAYLOAD_W-1:0] payload;
    } entry_t;

    entry_t            slots_q [DEPTH];
    entry_t            slots_d [DEPTH];
    // Extra top element is an empty entry shifted into the last slot on issue.
    entry_t            woken   [DEPTH+1];
    entry_t            new_e;
    logic [CW-1:0]     count_q, count_d, wr_ptr;
    logic [DEPTH-1:0]  valid, ready, grant;
    logic [IW-1:0]     sel_idx;
    logic              any_rdy, enq, iss;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            valid[i] = CW'(i) < count_q;
            ready[i] = valid[i] & slots_q[i].src1_rdy & slots_q[i].src2_rdy;
        end
    end

    sched_pick #(.N(DEPTH)) u_pick (
        .req   (ready),
        .grant (grant),
        .idx   (sel_idx),
        .any   (any_rdy)
    );

    always_comb begin
        issue_payload = '0;
        for (int i = 0; i < DEPTH; i++)
            issue_payload |= grant[i] ? slots_q[i].payload : '0;
    end

    // in_ready looks only at the registered count, so a full window refuses
    // enqueue even in a cycle where it also issues.
    assign in_ready    = count_q != CW'(DEPTH);
    assign stall_req   = ~in_ready;
    assign count       = count_q;
    assign issue_valid = any_rdy & ~flush;
    assign enq         = in_valid & in_ready;
    assign iss         = issue_valid & issue_ready;
    assign wr_ptr      = count_q - CW'(iss);

    always_comb begin
        // Incoming sources matching this cycle's broadcast are captured as ready.
        new_e = {in_src1_tag, in_src1_rdy | (wb_valid & (in_src1_tag == wb_tag)),
                 in_src2_tag, in_src2_rdy | (wb_valid & (in_src2_tag == wb_tag)),
                 in_payload};
        woken[DEPTH] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            woken[i] = slots_q[i];
            woken[i].src1_rdy = slots_q[i].src1_rdy | (wb_valid & valid[i] & (slots_q[i].src1_tag == wb_tag));
            woken[i].src2_rdy = slots_q[i].src2_rdy | (wb_valid & valid[i] & (slots_q[i].src2_tag == wb_tag));
        end
        for (int i = 0; i < DEPTH; i++) begin
            slots_d[i] = (iss && i >= int'(sel_idx)) ? woken[i+1] : woken[i];
            if (enq && CW'(i) == wr_ptr)
                slots_d[i] = new_e;
            if (flush) begin
                slots_d[i].src1_rdy = 1'b0;
                slots_d[i].src2_rdy = 1'b0;
            end
        end
        count_d = flush ? '0 : count_q + CW'(enq) - CW'(iss);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++)
                slots_q[i] <= '0;
        end else begin
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++)
                slots_q[i] <= slots_d[i];
        end
    end
endmodule

// File: tb/tb_issue_sched.sv
// tb_issue_sched: directed and randomized checks of issue_sched against a queue model.
module tb_issue_sched;
    import sched_pkg::*;

    localparam int DEPTH = 8;
    localparam int PW    = SCHED_PAYLOAD_W;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    preg_t         in_src1_tag = '0;
    preg_t         in_src2_tag = '0;
    logic          in_src1_rdy = 1'b0;
    logic          in_src2_rdy = 1'b0;
    logic [PW-1:0] in_payload = '0;
    logic          wb_valid = 1'b0;
    preg_t         wb_tag = '0;
    logic          flush = 1'b0;
    logic          issue_valid;
    logic          issue_ready = 1'b0;
    logic [PW-1:0] issue_payload;
    logic          stall_req;
    logic [CW-1:0] count;

    always #5 clk = ~clk;

    issue_sched #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_src1_tag   (in_src1_tag),
        .in_src2_tag   (in_src2_tag),
        .in_src1_rdy   (in_src1_rdy),
        .in_src2_rdy   (in_src2_rdy),
        .in_payload    (in_payload),
        .wb_valid      (wb_valid),
        .wb_tag        (wb_tag),
        .flush         (flush),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .issue_payload (issue_payload),
        .stall_req     (stall_req),
        .count         (count)
    );

    // Model: window as an age-ordered queue, index 0 oldest.
    sched_entry_t q[$];
    int n_cmp = 0;
    int n_err = 0;
    logic          obs_iv, obs_ir, obs_stall;
    logic [PW-1:0] obs_pl;
    logic [CW-1:0] obs_cnt;
    logic [PW-1:0] pa, pb, pc;

    task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic v, input preg_t t1, input logic r1, input preg_t t2, input logic r2);
        in_valid    = v;
        in_src1_tag = t1;
        in_src1_rdy = r1;
        in_src2_tag = t2;
        in_src2_rdy = r2;
        in_payload  = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Called at a falling edge with inputs already applied: checks outputs,
    // crosses one rising edge, updates the model, returns at the next falling edge.
    task automatic step();
        int s;
        logic ev, en, is;
        logic [PW-1:0] ep;
        sched_entry_t e;
        #1;
        s = -1;
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].src1_rdy && q[i].src2_rdy) s = i;
        ev = (s >= 0) && !flush;
        ep = (s >= 0) ? q[s].payload : '0;
        obs_iv = issue_valid;
        obs_pl = issue_payload;
        obs_ir = in_ready;
        obs_stall = stall_req;
        obs_cnt = count;
        chk("count", PW'(count), PW'(q.size()));
        chk("in_ready", PW'(in_ready), PW'(q.size() < DEPTH));
        chk("stall_req", PW'(stall_req), PW'(q.size() == DEPTH));
        chk("issue_valid", PW'(issue_valid), PW'(ev));
        chk("issue_payload", issue_payload, ep);
        en = in_valid && (q.size() < DEPTH);
        is = ev && issue_ready;
        e.src1_tag = in_src1_tag;
        e.src1_rdy = in_src1_rdy || (wb_valid && in_src1_tag == wb_tag);
        e.src2_tag = in_src2_tag;
        e.src2_rdy = in_src2_rdy || (wb_valid && in_src2_tag == wb_tag);
        e.payload  = in_payload;
        @(posedge clk);
        if (flush) q.delete();
        else begin
            if (wb_valid)
                foreach (q[i]) begin
                    if (q[i].src1_tag == wb_tag) q[i].src1_rdy = 1'b1;
                    if (q[i].src2_tag == wb_tag) q[i].src2_rdy = 1'b1;
                end
            if (is) q.delete(s);
            if (en) q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic clear();
        set_in(1'b0, '0, 1'b0, '0, 1'b0);
        wb_valid = 1'b0;
        issue_ready = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    initial begin
        int ir_pct;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_count", PW'(count), PW'(0));
        chk("rst_issue_valid", PW'(issue_valid), PW'(0));
        chk("rst_in_ready", PW'(in_ready), PW'(1));
        chk("rst_stall", PW'(stall_req), PW'(0));
        chk("rst_payload", issue_payload, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of operation with 5 waiting entries.
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, preg_t'(1), 1'b0, preg_t'(2), 1'b0);
            step();
        end
        set_in(1'b0, '0, 1'b0, '0, 1'b0);
        step();
        chk("mid_fill5", PW'(obs_cnt), PW'(5));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_count", PW'(count), PW'(0));
        chk("mid_rst_issue_valid", PW'(issue_valid), PW'(0));
        chk("mid_rst_in_ready", PW'(in_ready), PW'(1));
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // Age order.
        issue_ready = 1'b0;
        set_in(1'b1, '0, 1'b1, '0, 1'b1); pa = in_payload; step();
        set_in(1'b1, '0, 1'b1, '0, 1'b1); pb = in_payload; step();
        set_in(1'b1, '0, 1'b1, '0, 1'b1); pc = in_payload; step();
        in_valid = 1'b0;
        issue_ready = 1'b1;
        step(); chk("age_a", obs_pl, pa); chk("age_cnt3", PW'(obs_cnt), PW'(3));
        step(); chk("age_b", obs_pl, pb);
        step(); chk("age_c", obs_pl, pc);
        step(); chk("age_cnt0", PW'(obs_cnt), PW'(0));

        // Wakeup: younger ready entry overtakes, older one issues after broadcast.
        clear();
        set_in(1'b1, preg_t'(12), 1'b0, '0, 1'b1); pa = in_payload; step();
        set_in(1'b1, '0, 1'b1, '0, 1'b1); pb = in_payload; step();
        in_valid = 1'b0;
        issue_ready = 1'b1;
        step(); chk("wake_b_first", obs_pl, pb);
        wb_valid = 1'b1; wb_tag = preg_t'(12);
        step(); chk("wake_not_same_cycle", PW'(obs_iv), PW'(0));
        wb_valid = 1'b0;
        step(); chk("wake_a_valid", PW'(obs_iv), PW'(1)); chk("wake_a_payload", obs_pl, pa);

        // Same-cycle bypass on enqueue.
        clear();
        set_in(1'b1, '0, 1'b1, preg_t'(7), 1'b0); pa = in_payload;
        wb_valid = 1'b1; wb_tag = preg_t'(7); issue_ready = 1'b1;
        step();
        in_valid = 1'b0; wb_valid = 1'b0;
        step(); chk("bypass_valid", PW'(obs_iv), PW'(1)); chk("bypass_payload", obs_pl, pa);

        // Full window.
        clear();
        for (int i = 0; i < DEPTH; i++) begin
            set_in(1'b1, preg_t'(3), i == 0, preg_t'(3), i == 0);
            step();
        end
        set_in(1'b1, '0, 1'b1, '0, 1'b1);
        step();
        chk("full_in_ready", PW'(obs_ir), PW'(0));
        chk("full_stall", PW'(obs_stall), PW'(1));
        in_valid = 1'b0; issue_ready = 1'b1;
        step(); chk("full_9th_ignored", PW'(obs_cnt), PW'(DEPTH));
        issue_ready = 1'b0;
        step(); chk("full_ready_again", PW'(obs_ir), PW'(1)); chk("full_cnt7", PW'(obs_cnt), PW'(DEPTH - 1));

        // Flush beats enqueue, wakeup and issue in the same cycle.
        set_in(1'b1, '0, 1'b1, '0, 1'b1);
        step();
        flush = 1'b1; set_in(1'b1, '0, 1'b1, '0, 1'b1);
        wb_valid = 1'b1; wb_tag = preg_t'(3); issue_ready = 1'b1;
        step(); chk("flush_no_issue", PW'(obs_iv), PW'(0));
        flush = 1'b0; in_valid = 1'b0; wb_valid = 1'b0;
        step(); chk("flush_cnt0", PW'(obs_cnt), PW'(0)); chk("flush_empty", PW'(obs_iv), PW'(0));

        // Randomized traffic with varying execute acceptance rate.
        for (int b = 0; b < 6; b++) begin
            ir_pct = (b % 3 == 0) ? 20 : (b % 3 == 1) ? 60 : 95;
            repeat (500) begin
                set_in($urandom_range(0, 99) < 70, preg_t'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                       preg_t'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
                wb_valid = 1'($urandom_range(0, 1));
                wb_tag = preg_t'($urandom_range(0, 7));
                issue_ready = $urandom_range(0, 99) < ir_pct;
                flush = $urandom_range(0, 99) < 2;
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
